// File: rtl/d16_skid_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : d16_skid_pipeline
//  Purpose  : Elastic valid/ready pipeline stage for the d16 op/a/b/c bundle.
//             A main register feeds the outputs. A second (skid) register
//             catches the one bundle that can arrive while the consumer
//             stalls. Because of the skid register, in_ready comes straight
//             from a flop.
//  Options  : D16_SKID_STATS_EN adds the stall_cnt output. stall_cnt is a
//             saturating count of cycles with out_valid & !out_ready.
//  Ports    : sys_clk, sys_rst_n (async, active low), flush (sync)
//             in_valid/in_ready, op/a/b/c                 - upstream side
//             out_valid/out_ready, op_out/a_out/b_out/c_out - downstream side
//             stall_cnt[15:0]                  - only with D16_SKID_STATS_EN
//  Revision : 1.0 - initial release
// ============================================================================
module d16_skid_pipeline #(
    parameter int OP_W   = 8,
    parameter int DATA_W = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
`ifdef D16_SKID_STATS_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   op_out,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [DATA_W-1:0] c_out
);

    // State encoding: bit 0 is the main-valid flag and bit 1 is the skid-valid
    // flag. out_valid and in_ready are therefore read directly from flop bits.
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] FULL  = 2'b01;
    localparam logic [1:0] SKID  = 2'b11;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;

    logic [OP_W-1:0]   r_op_main,   r_op_skid;
    logic [DATA_W-1:0] r_a_main,    r_a_skid;
    logic [DATA_W-1:0] r_b_main,    r_b_skid;
    logic [DATA_W-1:0] r_c_main,    r_c_skid;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            // Only the valid flags clear. The data registers keep their contents.
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (in_valid) begin
                        w_load_main_in = 1'b1;
                        w_state_nxt    = FULL;
                    end
                end
                FULL: begin
                    if (in_valid) begin
                        if (out_ready) begin
                            w_load_main_in = 1'b1;
                        end else begin
                            w_load_skid = 1'b1;
                            w_state_nxt = SKID;
                        end
                    end else if (out_ready) begin
                        w_state_nxt = EMPTY;
                    end
                end
                SKID: begin
                    // in_ready is low in this state, so in_valid is ignored.
                    if (out_ready) begin
                        w_load_main_skid = 1'b1;
                        w_state_nxt      = FULL;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= EMPTY;
            r_op_main <= '0;
            r_a_main  <= '0;
            r_b_main  <= '0;
            r_c_main  <= '0;
            r_op_skid <= '0;
            r_a_skid  <= '0;
            r_b_skid  <= '0;
            r_c_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main_in) begin
                r_op_main <= op;
                r_a_main  <= a;
                r_b_main  <= b;
                r_c_main  <= c;
            end else if (w_load_main_skid) begin
                r_op_main <= r_op_skid;
                r_a_main  <= r_a_skid;
                r_b_main  <= r_b_skid;
                r_c_main  <= r_c_skid;
            end
            if (w_load_skid) begin
                r_op_skid <= op;
                r_a_skid  <= a;
                r_b_skid  <= b;
                r_c_skid  <= c;
            end
        end
    end

    assign out_valid = r_state[0];
    assign in_ready  = ~r_state[1];
    assign op_out    = r_op_main;
    assign a_out     = r_a_main;
    assign b_out     = r_b_main;
    assign c_out     = r_c_main;

`ifdef D16_SKID_STATS_EN
    logic [15:0] r_stall_cnt;

    // Saturating stall counter. Flush does not clear it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_state[0] && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_d16_skid_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : tb_d16_skid_pipeline
//  Purpose  : Directed self-checking bench for d16_skid_pipeline
//  Revision : 1.0 - initial release
// ============================================================================
module tb_d16_skid_pipeline;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  op;
    logic [15:0] a, b, c;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  op_out;
    logic [15:0] a_out, b_out, c_out;
`ifdef D16_SKID_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    d16_skid_pipeline #(.OP_W(8), .DATA_W(16)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .c         (c),
`ifdef D16_SKID_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_out    (op_out),
        .a_out     (a_out),
        .b_out     (b_out),
        .c_out     (c_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [15:0] av, input logic ordy);
        in_valid  = 1'b1;
        a         = av;
        out_ready = ordy;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 8'h00; a = 16'h0; b = 16'h0; c = 16'h0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_a_out",     32'(a_out),     32'd0);
        check("rst_op_out",    32'(op_out),    32'd0);
        #10 sys_rst_n = 1'b1;
        tick();

        // First bundle into an empty stage: one-cycle latency
        in_valid = 1'b1; op = 8'h12; a = 16'h0001; b = 16'h0002; c = 16'h0003; out_ready = 1'b1;
        tick();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_op",    32'(op_out),    32'h12);
        check("first_a",     32'(a_out),     32'h0001);
        check("first_b",     32'(b_out),     32'h0002);
        check("first_c",     32'(c_out),     32'h0003);
        check("first_rdy",   32'(in_ready),  32'd1);
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Back-to-back stream of 8 bundles
        for (int i = 1; i <= 8; i++) begin
            send(16'(i), 1'b1);
            tick();
            check("stream_a",     32'(a_out),     32'(i));
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_rdy",   32'(in_ready),  32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end", 32'(out_valid), 32'd0);

        // Skid capture under backpressure
        send(16'h00AA, 1'b1);
        tick();
        check("full_a", 32'(a_out), 32'h00AA);
        send(16'h00BB, 1'b0);
        tick();
        check("skid_rdy",   32'(in_ready),  32'd0);
        check("skid_a",     32'(a_out),     32'h00AA);
        check("skid_valid", 32'(out_valid), 32'd1);
        send(16'h00DD, 1'b0);          // ignored while in SKID
        tick();
        check("skid_hold_a",   32'(a_out),    32'h00AA);
        check("skid_hold_rdy", 32'(in_ready), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("unskid_a",   32'(a_out),    32'h00BB);
        check("unskid_rdy", 32'(in_ready), 32'd1);
        tick();
        check("unskid_empty", 32'(out_valid), 32'd0);

        // Flush while in SKID, with a simultaneous input
        send(16'h0011, 1'b1);
        tick();
        send(16'h0022, 1'b0);
        tick();
        check("pre_flush_rdy", 32'(in_ready), 32'd0);
        flush = 1'b1; send(16'h00CC, 1'b0);
        tick();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_rdy",   32'(in_ready),  32'd1);
        check("flush_keep_a", 32'(a_out),    32'h0011);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("post_flush_valid", 32'(out_valid), 32'd0);
        check("post_flush_a",     32'(a_out),     32'h0011);

        // Asynchronous reset while in SKID
        send(16'h0033, 1'b1);
        tick();
        send(16'h0044, 1'b0);
        tick();
        in_valid = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_rdy",   32'(in_ready),  32'd1);
        check("arst_a",     32'(a_out),     32'd0);
        check("arst_op",    32'(op_out),    32'd0);
        check("arst_c",     32'(c_out),     32'd0);
        #3 sys_rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        check("arst_after_valid", 32'(out_valid), 32'd0);

        // Load with out_ready low from EMPTY, then hold stable
        send(16'h0055, 1'b0);
        tick();
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_rdy",   32'(in_ready),  32'd1);
        in_valid = 1'b0;
        tick();
        check("hold_a_stable", 32'(a_out),     32'h0055);
        check("hold_v_stable", 32'(out_valid), 32'd1);

`ifdef D16_SKID_STATS_EN
        sys_rst_n = 1'b0;
        #1;
        check("stats_rst", 32'(stall_cnt), 32'd0);
        sys_rst_n = 1'b1;
        tick();
        send(16'h0066, 1'b0);
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("stats_3", 32'(stall_cnt), 32'd3);
        repeat (70000) @(posedge sys_clk);
        #1;
        check("stats_sat", 32'(stall_cnt), 32'hFFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("stats_flush", 32'(stall_cnt), 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
